fpu_unpack_sched: RTL and testbench

FPU_UNPACK_SCHED -- requirements
Module: fpu_unpack_sched

---
 rtl/fpu_unpack_sched_if.sv | 37 +++
 rtl/fpu_unpack_sched.sv | 157 +++++++++++++++
 tb/tb_fpu_unpack_sched.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_unpack_sched_if.sv
// Request, unpacker-drive and completion signals of the operand unpack scheduler.
// master = requester/consumer side, slave = scheduler side.
interface fpu_unpack_sched_if #(
  parameter int FLEN    = 64,
  parameter int FMTBITS = 2
);
  logic               ReqValid;
  logic               ReqReady;
  logic [FLEN-1:0]    X;
  logic [FLEN-1:0]    Y;
  logic [FLEN-1:0]    Z;
  logic [FMTBITS-1:0] Fmt;
  logic               XEn;
  logic               YEn;
  logic               ZEn;
  logic               Flush;
  logic [FLEN-1:0]    UnpA;
  logic [FMTBITS-1:0] UnpFmt;
  logic               UnpEn;
  logic               CapX;
  logic               CapY;
  logic               CapZ;
  logic               DoneValid;
  logic               DoneReady;
  logic               Busy;
  logic [31:0]        UnpCycles;

  modport master (
    output ReqValid, X, Y, Z, Fmt, XEn, YEn, ZEn, Flush, DoneReady,
    input  ReqReady, UnpA, UnpFmt, UnpEn, CapX, CapY, CapZ, DoneValid, Busy, UnpCycles
  );

  modport slave (
    input  ReqValid, X, Y, Z, Fmt, XEn, YEn, ZEn, Flush, DoneReady,
    output ReqReady, UnpA, UnpFmt, UnpEn, CapX, CapY, CapZ, DoneValid, Busy, UnpCycles
  );
endinterface

// File: rtl/fpu_unpack_sched.sv
// Sequences up to three latched operands through one shared unpacker, then signals completion.
// Optional unpack-cycle counter is built only when FPU_UNPACK_PERF_EN is defined.
module fpu_unpack_sched #(
  parameter int FLEN    = 64,
  parameter int FMTBITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  fpu_unpack_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    SX,
    SY,
    SZ,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [FLEN-1:0]    x_q;
  logic [FLEN-1:0]    y_q;
  logic [FLEN-1:0]    z_q;
  logic [FMTBITS-1:0] fmt_q;
  logic               x_en_q;
  logic               y_en_q;
  logic               z_en_q;
  logic               accept;
  logic [FLEN-1:0]    unp_a;
  logic               unp_en;
  logic               cap_x;
  logic               cap_y;
  logic               cap_z;
  logic               done_valid;

  assign accept = (state == IDLE) && !bus.Flush && bus.ReqValid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      fmt_q  <= '0;
      x_en_q <= 1'b0;
      y_en_q <= 1'b0;
      z_en_q <= 1'b0;
    end else if (accept) begin
      x_q    <= bus.X;
      y_q    <= bus.Y;
      z_q    <= bus.Z;
      fmt_q  <= bus.Fmt;
      x_en_q <= bus.XEn;
      y_en_q <= bus.YEn;
      z_en_q <= bus.ZEn;
    end
  end

  // The first hop uses the live enables because the latched copies only update on this edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.XEn)      state_next = SX;
          else if (bus.YEn) state_next = SY;
          else if (bus.ZEn) state_next = SZ;
          else              state_next = DONE;
        end
      end
      SX: begin
        if (y_en_q)      state_next = SY;
        else if (z_en_q) state_next = SZ;
        else             state_next = DONE;
      end
      SY: begin
        if (z_en_q) state_next = SZ;
        else        state_next = DONE;
      end
      SZ:      state_next = DONE;
      DONE:    if (bus.DoneReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.Flush) state_next = IDLE;
  end

  always_comb begin
    unp_a      = '0;
    unp_en     = 1'b0;
    cap_x      = 1'b0;
    cap_y      = 1'b0;
    cap_z      = 1'b0;
    done_valid = 1'b0;
    case (state)
      SX: begin
        unp_a  = x_q;
        unp_en = 1'b1;
        cap_x  = 1'b1;
      end
      SY: begin
        unp_a  = y_q;
        unp_en = 1'b1;
        cap_y  = 1'b1;
      end
      SZ: begin
        unp_a  = z_q;
        unp_en = 1'b1;
        cap_z  = 1'b1;
      end
      DONE:    done_valid = 1'b1;
      default: ;
    endcase
    // A flushed cycle must not be mistaken for a real issue or completion downstream.
    if (bus.Flush) begin
      unp_en     = 1'b0;
      cap_x      = 1'b0;
      cap_y      = 1'b0;
      cap_z      = 1'b0;
      done_valid = 1'b0;
    end
  end

  assign bus.ReqReady  = (state == IDLE) && !bus.Flush;
  assign bus.Busy      = (state != IDLE);
  assign bus.UnpA      = unp_a;
  assign bus.UnpFmt    = fmt_q;
  assign bus.UnpEn     = unp_en;
  assign bus.CapX      = cap_x;
  assign bus.CapY      = cap_y;
  assign bus.CapZ      = cap_z;
  assign bus.DoneValid = done_valid;

`ifdef FPU_UNPACK_PERF_EN
  logic [31:0] unp_cycles_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unp_cycles_q <= '0;
    end else if (unp_en && (unp_cycles_q != 32'hFFFF_FFFF)) begin
      unp_cycles_q <= unp_cycles_q + 32'd1;
    end
  end

  assign bus.UnpCycles = unp_cycles_q;
`else
  assign bus.UnpCycles = 32'd0;
`endif

endmodule

// File: tb/tb_fpu_unpack_sched.sv
// Directed bench for fpu_unpack_sched: inputs change and outputs are checked just after the falling edge.
module tb_fpu_unpack_sched;
  localparam int FLEN    = 64;
  localparam int FMTBITS = 2;

  localparam logic [63:0] XV = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] YV = 64'h4000_0000_0000_0000;
  localparam logic [63:0] ZV = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   errors   = 0;
  int   perf_exp = 0;
  bit   last_en  = 1'b0;

  fpu_unpack_sched_if #(.FLEN(FLEN), .FMTBITS(FMTBITS)) bus ();

  fpu_unpack_sched #(.FLEN(FLEN), .FMTBITS(FMTBITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOne(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic rr, input logic busy, input logic en,
                             input logic [2:0] cap, input logic dv, input logic [63:0] a);
    checkOne({tag, ".ReqReady"},  64'(bus.ReqReady), 64'(rr));
    checkOne({tag, ".Busy"},      64'(bus.Busy), 64'(busy));
    checkOne({tag, ".UnpEn"},     64'(bus.UnpEn), 64'(en));
    checkOne({tag, ".Cap"},       64'({bus.CapX, bus.CapY, bus.CapZ}), 64'(cap));
    checkOne({tag, ".DoneValid"}, 64'(bus.DoneValid), 64'(dv));
    checkOne({tag, ".UnpA"},      bus.UnpA, a);
`ifdef FPU_UNPACK_PERF_EN
    checkOne({tag, ".UnpCycles"}, 64'(bus.UnpCycles), 64'(perf_exp));
`else
    checkOne({tag, ".UnpCycles"}, 64'(bus.UnpCycles), 64'd0);
`endif
    last_en = en;
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] x, input logic [63:0] y,
                               input logic [63:0] z, input logic [1:0] fmt, input logic [2:0] ens,
                               input logic flush, input logic done_ready);
    bus.ReqValid  = valid;
    bus.X         = x;
    bus.Y         = y;
    bus.Z         = z;
    bus.Fmt       = fmt;
    bus.XEn       = ens[2];
    bus.YEn       = ens[1];
    bus.ZEn       = ens[0];
    bus.Flush     = flush;
    bus.DoneReady = done_ready;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
`ifdef FPU_UNPACK_PERF_EN
    if (last_en) perf_exp++;
`endif
  endtask

  task automatic idleInputs(input logic done_ready);
    applyStimulus(1'b0, JUNK, JUNK, JUNK, 2'b11, 3'b000, 1'b0, done_ready);
  endtask

  initial begin
    reset = 1'b1;
    idleInputs(1'b1);
    checkOutput("reset_held", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    checkOne("reset_held.UnpFmt", 64'(bus.UnpFmt), 64'd0);
    tick();
    reset = 1'b0;
    idleInputs(1'b1);
    checkOutput("reset_after", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();

    // Full set, Fmt=01; inputs scrambled after accept to prove latching.
    applyStimulus(1'b1, XV, YV, ZV, 2'b01, 3'b111, 1'b0, 1'b1);
    checkOutput("full_c0", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("full_c1", 1'b0, 1'b1, 1'b1, 3'b100, 1'b0, XV);
    checkOne("full_c1.UnpFmt", 64'(bus.UnpFmt), 64'd1);
    tick();
    idleInputs(1'b1);
    checkOutput("full_c2", 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, YV);
    tick();
    idleInputs(1'b1);
    checkOutput("full_c3", 1'b0, 1'b1, 1'b1, 3'b001, 1'b0, ZV);
    tick();
    idleInputs(1'b1);
    checkOutput("full_c4", 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 64'd0);
    checkOne("full_c4.UnpFmt", 64'(bus.UnpFmt), 64'd1);
    tick();
    idleInputs(1'b1);
    checkOutput("full_c5", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    checkOne("full_c5.UnpFmt", 64'(bus.UnpFmt), 64'd1);
    tick();

    // Sparse: only Y enabled, Fmt=10.
    applyStimulus(1'b1, XV, YV, ZV, 2'b10, 3'b010, 1'b0, 1'b1);
    checkOutput("sparse_c0", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("sparse_c1", 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, YV);
    checkOne("sparse_c1.UnpFmt", 64'(bus.UnpFmt), 64'd2);
    tick();
    idleInputs(1'b1);
    checkOutput("sparse_c2", 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("sparse_c3", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();

    // Empty request completes one cycle after accept without issuing.
    applyStimulus(1'b1, XV, YV, ZV, 2'b00, 3'b000, 1'b0, 1'b1);
    checkOutput("empty_c0", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("empty_c1", 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("empty_c2", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();

    // Backpressure: five stalled DONE cycles with a competing request offered.
    applyStimulus(1'b1, XV, YV, ZV, 2'b00, 3'b000, 1'b0, 1'b0);
    checkOutput("bp_c0", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, XV, YV, ZV, 2'b01, 3'b111, 1'b0, 1'b0);
      checkOutput($sformatf("bp_stall%0d", i), 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 64'd0);
      tick();
    end
    idleInputs(1'b1);
    checkOutput("bp_release", 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("bp_idle", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();

    // Flush in SY of a full request, then a Z-only request runs normally.
    applyStimulus(1'b1, XV, YV, ZV, 2'b01, 3'b111, 1'b0, 1'b1);
    checkOutput("flush_c0", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("flush_c1", 1'b0, 1'b1, 1'b1, 3'b100, 1'b0, XV);
    tick();
    applyStimulus(1'b0, JUNK, JUNK, JUNK, 2'b11, 3'b000, 1'b1, 1'b1);
    checkOutput("flush_sy", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, YV);
    tick();
    idleInputs(1'b1);
    checkOutput("flush_idle", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    applyStimulus(1'b1, XV, YV, ZV, 2'b00, 3'b001, 1'b0, 1'b1);
    checkOutput("after_c0", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("after_c1", 1'b0, 1'b1, 1'b1, 3'b001, 1'b0, ZV);
    tick();
    idleInputs(1'b1);
    checkOutput("after_c2", 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("after_c3", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();

    // Flush beats ReqValid in IDLE.
    applyStimulus(1'b1, XV, YV, ZV, 2'b01, 3'b111, 1'b1, 1'b1);
    checkOutput("flushreq_c0", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("flushreq_c1", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();

    // Flush with DoneReady in DONE suppresses completion.
    applyStimulus(1'b1, XV, YV, ZV, 2'b00, 3'b000, 1'b0, 1'b1);
    checkOutput("flushdone_c0", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    applyStimulus(1'b0, JUNK, JUNK, JUNK, 2'b11, 3'b000, 1'b1, 1'b1);
    checkOutput("flushdone_c1", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("flushdone_c2", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();

    // Async reset pulse between edges while in SX.
    applyStimulus(1'b1, XV, YV, ZV, 2'b01, 3'b111, 1'b0, 1'b1);
    checkOutput("rst_c0", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("rst_sx", 1'b0, 1'b1, 1'b1, 3'b100, 1'b0, XV);
    reset    = 1'b1;
    perf_exp = 0;
    #1;
    checkOutput("rst_asserted", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    checkOne("rst_asserted.UnpFmt", 64'(bus.UnpFmt), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_released", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("rst_next1", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);
    tick();
    idleInputs(1'b1);
    checkOutput("rst_next2", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
